morse_symbol_decoder: RTL and testbench

- Downstream stage of the dot/dash classifier. Consumes single-cycle Dot/Dash symbol pulses and measures the silent gaps between them.
- Assembles up to 5 symbols into a pattern, then emits a registered character code when a letter gap elapses, and a space code when a word gap elapses.
- Keeps a 4-character history (Disp3..Disp0) that the top level drives straight onto the four SSDs.

---
 rtl/morse_pkg.sv | 31 +++
 rtl/morse_lut.sv | 58 +++++
 rtl/morse_symbol_decoder.sv | 145 ++++++++++++++
 tb/tb_morse_symbol_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared codes, states and limits for the Morse symbol decoder.
package morse_pkg;

    localparam logic [5:0] CODE_A = 6'd0,  CODE_B = 6'd1,  CODE_C = 6'd2;
    localparam logic [5:0] CODE_D = 6'd3,  CODE_E = 6'd4,  CODE_F = 6'd5;
    localparam logic [5:0] CODE_G = 6'd6,  CODE_H = 6'd7,  CODE_I = 6'd8;
    localparam logic [5:0] CODE_J = 6'd9,  CODE_K = 6'd10, CODE_L = 6'd11;
    localparam logic [5:0] CODE_M = 6'd12, CODE_N = 6'd13, CODE_O = 6'd14;
    localparam logic [5:0] CODE_P = 6'd15, CODE_Q = 6'd16, CODE_R = 6'd17;
    localparam logic [5:0] CODE_S = 6'd18, CODE_T = 6'd19, CODE_U = 6'd20;
    localparam logic [5:0] CODE_V = 6'd21, CODE_W = 6'd22, CODE_X = 6'd23;
    localparam logic [5:0] CODE_Y = 6'd24, CODE_Z = 6'd25;

    localparam logic [5:0] CODE_0 = 6'd26, CODE_1 = 6'd27, CODE_2 = 6'd28;
    localparam logic [5:0] CODE_3 = 6'd29, CODE_4 = 6'd30, CODE_5 = 6'd31;
    localparam logic [5:0] CODE_6 = 6'd32, CODE_7 = 6'd33, CODE_8 = 6'd34;
    localparam logic [5:0] CODE_9 = 6'd35;

    localparam logic [5:0] CODE_SPACE = 6'd36;
    localparam logic [5:0] CODE_ERR   = 6'd63;

    localparam int MAX_SYMS = 5;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT,
        WAIT_WORD
    } state_t;

endpackage

// File: rtl/morse_lut.sv
// Pattern/length to character code lookup.
// Dot = 0, dash = 1, first symbol in the highest used bit.
module morse_lut
    import morse_pkg::*;
(
    input  logic [4:0] pattern,
    input  logic [2:0] len,
    output logic [5:0] code
);

    logic [7:0] key;

    assign key = {len, pattern};

    always_comb begin
        code = CODE_ERR;
        case (key)
            {3'd1, 5'b00000}: code = CODE_E;
            {3'd1, 5'b00001}: code = CODE_T;
            {3'd2, 5'b00000}: code = CODE_I;
            {3'd2, 5'b00001}: code = CODE_A;
            {3'd2, 5'b00010}: code = CODE_N;
            {3'd2, 5'b00011}: code = CODE_M;
            {3'd3, 5'b00000}: code = CODE_S;
            {3'd3, 5'b00001}: code = CODE_U;
            {3'd3, 5'b00010}: code = CODE_R;
            {3'd3, 5'b00011}: code = CODE_W;
            {3'd3, 5'b00100}: code = CODE_D;
            {3'd3, 5'b00101}: code = CODE_K;
            {3'd3, 5'b00110}: code = CODE_G;
            {3'd3, 5'b00111}: code = CODE_O;
            {3'd4, 5'b00000}: code = CODE_H;
            {3'd4, 5'b00001}: code = CODE_V;
            {3'd4, 5'b00010}: code = CODE_F;
            {3'd4, 5'b00100}: code = CODE_L;
            {3'd4, 5'b00110}: code = CODE_P;
            {3'd4, 5'b00111}: code = CODE_J;
            {3'd4, 5'b01000}: code = CODE_B;
            {3'd4, 5'b01001}: code = CODE_X;
            {3'd4, 5'b01010}: code = CODE_C;
            {3'd4, 5'b01011}: code = CODE_Y;
            {3'd4, 5'b01100}: code = CODE_Z;
            {3'd4, 5'b01101}: code = CODE_Q;
            {3'd5, 5'b11111}: code = CODE_0;
            {3'd5, 5'b01111}: code = CODE_1;
            {3'd5, 5'b00111}: code = CODE_2;
            {3'd5, 5'b00011}: code = CODE_3;
            {3'd5, 5'b00001}: code = CODE_4;
            {3'd5, 5'b00000}: code = CODE_5;
            {3'd5, 5'b10000}: code = CODE_6;
            {3'd5, 5'b11000}: code = CODE_7;
            {3'd5, 5'b11100}: code = CODE_8;
            {3'd5, 5'b11110}: code = CODE_9;
            default:          code = CODE_ERR;
        endcase
    end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Collects dot/dash pulses into characters, emits codes on letter gaps
// and a single space on word gaps, and keeps a 4-character history.
module morse_symbol_decoder #(
    parameter int LETTER_GAP = 50_000_000,
    parameter int WORD_GAP   = 150_000_000,
    parameter int GAP_W      = 28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Dot,
    input  logic       Dash,
    input  logic       Clear,
    output logic [5:0] Char_code,
    output logic       Char_valid,
    output logic       Char_err,
    output logic [2:0] Sym_cnt,
    output logic       Busy,
    output logic [5:0] Disp0,
    output logic [5:0] Disp1,
    output logic [5:0] Disp2,
    output logic [5:0] Disp3
);
    import morse_pkg::*;

    localparam logic [GAP_W-1:0] LG_END = GAP_W'(LETTER_GAP - 1);
    localparam logic [GAP_W-1:0] WG_END = GAP_W'(WORD_GAP - 1);

    state_t           state;
    logic [4:0]       pattern;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_inc;
    logic             ovf;
    logic             conf;
    logic             sym;
    logic [5:0]       lut_code;
    logic [5:0]       emit_code;

    morse_lut u_lut (
        .pattern (pattern),
        .len     (Sym_cnt),
        .code    (lut_code)
    );

    assign sym       = Dot | Dash;
    assign gap_inc   = (gap_cnt == '1) ? gap_cnt : gap_cnt + GAP_W'(1);
    assign emit_code = (ovf || conf) ? CODE_ERR : lut_code;
    assign Busy      = (state == COLLECT) || (state == EMIT);

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            state      <= IDLE;
            pattern    <= '0;
            Sym_cnt    <= '0;
            gap_cnt    <= '0;
            ovf        <= 1'b0;
            conf       <= 1'b0;
            Char_code  <= CODE_SPACE;
            Char_valid <= 1'b0;
            Char_err   <= 1'b0;
            Disp0      <= CODE_SPACE;
            Disp1      <= CODE_SPACE;
            Disp2      <= CODE_SPACE;
            Disp3      <= CODE_SPACE;
        end else begin
            Char_valid <= 1'b0;
            Char_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sym) begin
                        state   <= COLLECT;
                        pattern <= {4'b0, Dash};
                        Sym_cnt <= 3'd1;
                        gap_cnt <= '0;
                        ovf     <= 1'b0;
                        conf    <= Dot & Dash;
                    end
                end
                COLLECT: begin
                    if (sym) begin
                        gap_cnt <= '0;
                        if (Dot && Dash) conf <= 1'b1;
                        // A sixth symbol poisons the character but is not stored
                        if (Sym_cnt == 3'(MAX_SYMS)) begin
                            ovf <= 1'b1;
                        end else begin
                            pattern <= {pattern[3:0], Dash};
                            Sym_cnt <= Sym_cnt + 3'd1;
                        end
                    end else begin
                        gap_cnt <= gap_inc;
                        if (gap_cnt == LG_END) state <= EMIT;
                    end
                end
                EMIT: begin
                    Char_code  <= emit_code;
                    Char_valid <= 1'b1;
                    Char_err   <= (emit_code == CODE_ERR);
                    Disp3      <= Disp2;
                    Disp2      <= Disp1;
                    Disp1      <= Disp0;
                    Disp0      <= emit_code;
                    // A symbol arriving here starts the next character
                    if (sym) begin
                        state   <= COLLECT;
                        pattern <= {4'b0, Dash};
                        Sym_cnt <= 3'd1;
                        gap_cnt <= '0;
                        ovf     <= 1'b0;
                        conf    <= Dot & Dash;
                    end else begin
                        state   <= WAIT_WORD;
                        pattern <= '0;
                        Sym_cnt <= '0;
                        gap_cnt <= gap_inc;
                        ovf     <= 1'b0;
                        conf    <= 1'b0;
                    end
                end
                WAIT_WORD: begin
                    if (sym) begin
                        state   <= COLLECT;
                        pattern <= {4'b0, Dash};
                        Sym_cnt <= 3'd1;
                        gap_cnt <= '0;
                        ovf     <= 1'b0;
                        conf    <= Dot & Dash;
                    end else if (gap_cnt == WG_END) begin
                        state      <= IDLE;
                        gap_cnt    <= '0;
                        Char_code  <= CODE_SPACE;
                        Char_valid <= 1'b1;
                        Disp3      <= Disp2;
                        Disp2      <= Disp1;
                        Disp1      <= Disp0;
                        Disp0      <= CODE_SPACE;
                    end else begin
                        gap_cnt <= gap_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed self-checking bench for morse_symbol_decoder.
// Short gaps keep letter/word timing visible in a few dozen cycles.
module tb_morse_symbol_decoder;

    localparam int LG = 8;
    localparam int WG = 20;

    logic       Clk;
    logic       Reset;
    logic       Dot;
    logic       Dash;
    logic       Clear;
    logic [5:0] Char_code;
    logic       Char_valid;
    logic       Char_err;
    logic [2:0] Sym_cnt;
    logic       Busy;
    logic [5:0] Disp0;
    logic [5:0] Disp1;
    logic [5:0] Disp2;
    logic [5:0] Disp3;

    int nvec;
    int nerr;
    int cyc;
    int e0;
    int valid_cnt;
    int last_code;
    int last_err;
    int last_edge;
    int n0;

    morse_symbol_decoder #(
        .LETTER_GAP (LG),
        .WORD_GAP   (WG),
        .GAP_W      (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Dot        (Dot),
        .Dash       (Dash),
        .Clear      (Clear),
        .Char_code  (Char_code),
        .Char_valid (Char_valid),
        .Char_err   (Char_err),
        .Sym_cnt    (Sym_cnt),
        .Busy       (Busy),
        .Disp0      (Disp0),
        .Disp1      (Disp1),
        .Disp2      (Disp2),
        .Disp3      (Disp3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        valid_cnt = 0;
        last_code = 0;
        last_err  = 0;
        last_edge = 0;
    end

    always @(negedge Clk) begin
        if (Char_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_code <= Char_code;
            last_err  <= Char_err;
            last_edge <= cyc;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sym(input logic d, input logic h);
        Dot  = d;
        Dash = h;
        tick;
        Dot  = 1'b0;
        Dash = 1'b0;
        e0   = cyc;
    endtask

    task automatic send(input int n, input logic [4:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            sym(~bits[i], bits[i]);
        end
    endtask

    task automatic wait_char(input string tag);
        int n;
        int k;
        n = valid_cnt;
        k = 0;
        while (valid_cnt == n && k < 100) begin
            tick;
            k++;
        end
        chk({tag, "_seen"}, valid_cnt - n, 1);
    endtask

    task automatic expect_char(input string tag, input int code, input int err);
        wait_char(tag);
        chk({tag, "_code"}, last_code, code);
        chk({tag, "_err"}, last_err, err);
        chk({tag, "_lat"}, last_edge - e0, LG + 1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_cnt"}, Sym_cnt, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_valid"}, Char_valid, 0);
        chk({tag, "_d0"}, Disp0, 36);
        chk({tag, "_d1"}, Disp1, 36);
        chk({tag, "_d2"}, Disp2, 36);
        chk({tag, "_d3"}, Disp3, 36);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec  = 0;
        nerr  = 0;
        Reset = 1'b1;
        Clear = 1'b0;
        Dot   = 1'b0;
        Dash  = 1'b0;
        repeat (3) tick;
        Reset = 1'b0;
        chk("rst_code", Char_code, 36);
        chk("rst_err", Char_err, 0);
        check_cleared("rst");

        sym(1'b1, 1'b0);
        repeat (3) tick;
        sym(1'b0, 1'b1);
        expect_char("A", 0, 0);
        wait_char("space");
        chk("space_code", last_code, 36);
        chk("space_lat", last_edge - e0, WG);
        chk("hist_d0", Disp0, 36);
        chk("hist_d1", Disp1, 0);
        n0 = valid_cnt;
        repeat (40) tick;
        chk("one_space", valid_cnt - n0, 0);
        chk("idle_busy", Busy, 0);

        send(4, 5'b01000);
        expect_char("B", 1, 0);
        send(5, 5'b11111);
        expect_char("d0", 26, 0);
        send(5, 5'b00001);
        expect_char("d4", 30, 0);
        chk("hist_b", Disp2, 1);

        send(5, 5'b00000);
        sym(1'b1, 1'b0);
        chk("sat_cnt", Sym_cnt, 5);
        expect_char("ovf", 63, 1);

        sym(1'b1, 1'b1);
        expect_char("conf", 63, 1);

        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        n0 = valid_cnt;
        sym(1'b1, 1'b0);
        repeat (7) tick;
        sym(1'b0, 1'b1);
        chk("late_cnt", Sym_cnt, 2);
        expect_char("late", 0, 0);
        chk("late_once", valid_cnt - n0, 1);

        send(3, 5'b00000);
        Clear = 1'b1;
        tick;
        Clear = 1'b0;
        check_cleared("clr");
        n0 = valid_cnt;
        repeat (30) tick;
        chk("clr_quiet", valid_cnt - n0, 0);

        send(1, 5'b00001);
        expect_char("T", 19, 0);
        send(3, 5'b00000);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check_cleared("mrst");
        n0 = valid_cnt;
        repeat (30) tick;
        chk("mrst_quiet", valid_cnt - n0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
